pipeline_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RV32I pipeline.

---
 rtl/pipeline_hazard_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: post-reset fill window,
// load-use bubbles, EX redirects, fetch wait and data-memory freeze with watchdog.
module pipeline_hazard_ctrl #(
  parameter int RST_HOLD   = 4,
  parameter int FREEZE_MAX = 255,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  input  logic             ex_redirect,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             pc_we,
  output logic             if_id_stall_n,
  output logic             if_id_flush,
  output logic             id_ex_stall_n,
  output logic             id_ex_flush,
  output logic             ex_mem_stall_n,
  output logic             err_freeze_to,
  output logic [CNT_W-1:0] cnt_stall,
  output logic [CNT_W-1:0] cnt_flush
);

  // state  | meaning
  // FILL   | post-reset window, pipeline held flushed for RST_HOLD cycles
  // RUN    | normal issue with hazard resolution
  // FREEZE | dmem_busy seen, whole pipeline held; release cycle uses RUN rules
  typedef enum logic [1:0] {S_FILL, S_RUN, S_FREEZE} state_t;

  localparam int FILL_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam int FRZ_W  = $clog2(FREEZE_MAX + 1);

  state_t            state, state_nxt;
  logic [FILL_W-1:0] fill_cnt;
  logic [FRZ_W-1:0]  freeze_cnt, freeze_nxt;
  logic              load_use;
  logic              redirect_evt;
  logic              stall_evt;

  always_comb begin
    load_use = ex_is_load && (ex_rd != 5'd0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
  end

  always_comb begin
    pc_we          = 1'b1;
    if_id_stall_n  = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_stall_n  = 1'b1;
    id_ex_flush    = 1'b0;
    ex_mem_stall_n = 1'b1;
    redirect_evt   = 1'b0;
    state_nxt      = state;
    freeze_nxt     = freeze_cnt;
    case (state)
      S_FILL: begin
        pc_we       = 1'b0;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (fill_cnt == FILL_W'(RST_HOLD - 1)) state_nxt = S_RUN;
      end
      default: begin
        if (dmem_busy) begin
          pc_we          = 1'b0;
          if_id_stall_n  = 1'b0;
          id_ex_stall_n  = 1'b0;
          ex_mem_stall_n = 1'b0;
          state_nxt      = S_FREEZE;
          // freeze_cnt is 0 in RUN, so the saturating increment also yields the initial 1
          freeze_nxt     = (freeze_cnt == FRZ_W'(FREEZE_MAX)) ? freeze_cnt
                                                              : freeze_cnt + FRZ_W'(1);
        end else begin
          state_nxt  = S_RUN;
          freeze_nxt = '0;
          if (ex_redirect) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            redirect_evt = 1'b1;
          end else if (load_use) begin
            pc_we         = 1'b0;
            if_id_stall_n = 1'b0;
            id_ex_flush   = 1'b1;
          end else if (!imem_ready) begin
            pc_we       = 1'b0;
            if_id_flush = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb stall_evt = (state != S_FILL) && !pc_we;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state         <= S_FILL;
      fill_cnt      <= '0;
      freeze_cnt    <= '0;
      err_freeze_to <= 1'b0;
      cnt_stall     <= '0;
      cnt_flush     <= '0;
    end else begin
      state      <= state_nxt;
      freeze_cnt <= freeze_nxt;
      if (state == S_FILL) fill_cnt <= fill_cnt + FILL_W'(1);
      if ((state != S_FILL) && dmem_busy && (freeze_nxt == FRZ_W'(FREEZE_MAX)))
        err_freeze_to <= 1'b1;
      if (stall_evt && (cnt_stall != '1)) cnt_stall <= cnt_stall + CNT_W'(1);
      if (redirect_evt && (cnt_flush != '1)) cnt_flush <= cnt_flush + CNT_W'(1);
    end
  end

endmodule
